// File: rtl/mux_rr_scheduler_pkg.sv
// mux_sched_pkg: shared types, default sizes and the round-robin search
// helper for the mux_rr_scheduler block.
//
// Contents:
//   state_t        scheduler FSM states (IDLE, GRANTED)
//   DEFAULT_*      default requester count, data width and burst limit
//   MAX_N          largest supported requester count
//   next_rr_index  first requesting index at or above ptr, wrapping at n
package mux_sched_pkg;

    localparam int DEFAULT_N         = 4;
    localparam int DEFAULT_W         = 8;
    localparam int DEFAULT_MAX_BURST = 8;
    localparam int MAX_N             = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    // Searches ptr, ptr+1, ... n-1, 0, ... ptr-1 and returns the first index
    // whose request bit is set. If nothing is requesting, ptr is returned and
    // the caller is expected not to use it.
    function automatic logic [3:0] next_rr_index(input logic [MAX_N-1:0] req,
                                                 input logic [3:0]       ptr,
                                                 input int               n);
        logic [3:0] idx;
        logic       found;
        int         cand;
        idx   = ptr;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                cand = int'(ptr) + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (!found && req[cand[3:0]]) begin
                    idx   = cand[3:0];
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// mux_rr_scheduler_if: bundles the requester side and the downstream output
// stage of the round-robin scheduler.
//
// Signals:
//   req, req_last, data_in   per-requester request, last-beat flag, packed data
//   grant                    one-hot grant, also the ready to each requester
//   select, busy             current/most recent grantee index, burst active
//   data_out, out_valid      registered output beat toward the consumer
//   out_ready                consumer accepts the beat
//
// Modports: master = the scheduler, slave = requesters plus consumer.
interface mux_rr_scheduler_if
    import mux_sched_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int W     = DEFAULT_W,
    parameter int SEL_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic [N-1:0]     req_last;
    logic [N*W-1:0]   data_in;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] select;
    logic             busy;
    logic [W-1:0]     data_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  req, req_last, data_in, out_ready,
        output grant, select, busy, data_out, out_valid
    );

    modport slave (
        output req, req_last, data_in, out_ready,
        input  grant, select, busy, data_out, out_valid
    );

endinterface

// File: rtl/mux_rr_scheduler_mux.sv
// mux_n_to_1: purely combinational N-to-1 data selector.
//
// Ports:
//   data_in   N*W packed inputs, input i at [i*W +: W]
//   sel       index of the input to forward
//   data_out  selected slice, or 0 when sel >= N
module mux_n_to_1
    import mux_sched_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int W     = DEFAULT_W,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*W-1:0]   data_in,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     data_out
);

    // Compare against every legal index so a non-power-of-two N still
    // yields zero for the unused select codes.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                data_out = data_in[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin scheduler sharing one N-to-1 data mux among
// N requesters. A grantee keeps the mux for one burst, ended by its last-beat
// flag or after MAX_BURST beats; each beat is registered into an output stage
// with a valid/ready handshake. One arbitration bubble separates bursts.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   mux_rr_scheduler_if.master (req/req_last/data_in/out_ready in,
//         grant/select/busy/data_out/out_valid out)
//
// Optional build macro MUX_SCHED_TIMEOUT_EN: releases a grant whose owner has
// left its request low for TIMEOUT consecutive cycles. Without it the grant is
// held until a last beat or the burst limit.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int W         = DEFAULT_W,
    parameter int SEL_W     = $clog2(N),
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int TIMEOUT   = 16
) (
    input logic             clk,
    input logic             rst,
    mux_rr_scheduler_if.master bus
);

    localparam int CNT_W = 8;

    if (N < 2 || N > MAX_N || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT < 1) begin : g_bad_params
        $error("mux_rr_scheduler: parameter out of legal range");
    end

    state_t           state, state_next;
    logic [SEL_W-1:0] ptr, ptr_next;
    logic [SEL_W-1:0] sel, sel_next;
    logic [CNT_W-1:0] beat_cnt, beat_next;
    logic [W-1:0]     data_q, data_sel;
    logic             out_valid_q;
    logic             can_accept, xfer, last_beat, release_burst;
    logic [SEL_W-1:0] arb_idx, released_ptr;
    logic             timed_out;

    mux_n_to_1 #(.N(N), .W(W), .SEL_W(SEL_W)) u_mux (
        .data_in  (bus.data_in),
        .sel      (sel),
        .data_out (data_sel)
    );

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;

    assign timed_out = (state == GRANTED) && !bus.req[sel] &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Counts consecutive granted cycles in which the owner is not requesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != GRANTED || bus.req[sel] || timed_out) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Next-state logic: arbitration in IDLE, beat counting and release in
    // GRANTED. The released index becomes lowest priority by moving ptr past it.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        sel_next     = sel;
        beat_next    = beat_cnt;
        can_accept   = !out_valid_q || bus.out_ready;
        xfer         = (state == GRANTED) && bus.req[sel] && can_accept;
        last_beat    = bus.req_last[sel] || (beat_cnt == CNT_W'(MAX_BURST - 1));
        release_burst = (xfer && last_beat) || timed_out;
        released_ptr = (sel == SEL_W'(N - 1)) ? '0 : sel + SEL_W'(1);
        arb_idx      = SEL_W'(next_rr_index(MAX_N'(bus.req), 4'(ptr), N));
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_next = GRANTED;
                    sel_next   = arb_idx;
                    beat_next  = '0;
                end
            end
            GRANTED: begin
                if (xfer) begin
                    beat_next = beat_cnt + CNT_W'(1);
                end
                if (release_burst) begin
                    state_next = IDLE;
                    ptr_next   = released_ptr;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            sel      <= sel_next;
            beat_cnt <= beat_next;
        end
    end

    // Output stage: a new beat overwrites one being popped in the same cycle,
    // which keeps a burst at one beat per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            data_q      <= data_sel;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= out_valid_q && !bus.out_ready;
        end
    end

    assign bus.grant     = ((state == GRANTED) && can_accept) ? (N'(1) << sel) : '0;
    assign bus.select    = sel;
    assign bus.busy      = (state == GRANTED);
    assign bus.data_out  = data_q;
    assign bus.out_valid = out_valid_q;

endmodule
